// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the RV32I hazard logic: scoreboard entry layout and
// operand-forwarding select encoding.
package rv32i_types;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } sb_entry_t;

    // Select width for the default three tracked stages.
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 2'd0;
    localparam fwd_sel_t FWD_EX      = 2'd1;
    localparam fwd_sel_t FWD_MEM     = 2'd2;
    localparam fwd_sel_t FWD_WB      = 2'd3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard signal bundle.
interface hazard_scoreboard_if #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 32
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    // advance is the pipeline-wide ready: entries move only when it is high.
    // stall is combinational back-pressure on ID, valid only with id_valid.
    logic                              id_valid;
    logic [NUM_SRC-1:0][4:0]           id_rs;
    logic [NUM_SRC-1:0]                id_rs_used;
    logic [4:0]                        id_rd;
    logic                              id_load_regfile;
    logic                              id_mem_read;
    logic                              advance;
    logic                              flush;
    logic                              cnt_clear;
    logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel;
    logic                              stall;
    logic [CNT_W-1:0]                  stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_load_regfile,
               id_mem_read, advance, flush, cnt_clear,
        input  fwd_sel, stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_load_regfile,
               id_mem_read, advance, flush, cnt_clear,
        output fwd_sel, stall, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_sb_src_match.sv
// Per-source priority match over the in-flight destination tags; the
// youngest matching stage wins and flags a load-use hazard if not yet ready.
module sb_src_match
    import rv32i_types::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  sb_entry_t [NUM_STAGES-1:0] i_entries,
    input  logic [4:0]                 i_rs,
    input  logic                       i_rs_used,
    output logic [SEL_W-1:0]           o_sel,
    output logic                       o_hazard
);

    always_comb begin
        o_sel    = '0;
        o_hazard = 1'b0;
        // Scan oldest to youngest so the youngest match is the last write.
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (i_rs_used && (i_rs != 5'd0) && i_entries[k-1].valid &&
                i_entries[k-1].wr && (i_entries[k-1].rd == i_rs)) begin
                o_sel    = SEL_W'(k);
                o_hazard = i_entries[k-1].ld && (k < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand-forwarding and load-use hazard unit: tracks destination tags from
// EX to the last write-back stage, selects forwarding sources, counts stalls.
module hazard_scoreboard
    import rv32i_types::*;
#(
    parameter int NUM_SRC          = 2,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FLUSH_STAGES     = 1,
    parameter int CNT_W            = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb_if
);

    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    sb_entry_t [NUM_STAGES-1:0]    r_entries;
    logic [CNT_W-1:0]              r_stall_count;

    logic [NUM_SRC-1:0][SEL_W-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]            w_hazard;
    logic                          w_stall;
    sb_entry_t                     w_new_entry;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        sb_src_match #(
            .NUM_STAGES       (NUM_STAGES),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W)
        ) u_match (
            .i_entries (r_entries),
            .i_rs      (sb_if.id_rs[s]),
            .i_rs_used (sb_if.id_rs_used[s]),
            .o_sel     (w_fwd_sel[s]),
            .o_hazard  (w_hazard[s])
        );
    end

    assign w_stall = sb_if.id_valid & (|w_hazard);

    // A stalled ID instruction enters stage 1 as a bubble.
    always_comb begin
        w_new_entry.valid = sb_if.id_valid & ~w_stall;
        w_new_entry.rd    = sb_if.id_rd;
        w_new_entry.wr    = sb_if.id_load_regfile;
        w_new_entry.ld    = sb_if.id_mem_read;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entries <= '0;
        end else begin
            if (sb_if.advance) begin
                for (int k = 1; k < NUM_STAGES; k++) begin
                    r_entries[k] <= r_entries[k-1];
                end
                r_entries[0] <= w_new_entry;
            end
            // Flush is applied after shift/hold, so it also kills while frozen.
            if (sb_if.flush) begin
                for (int k = 0; k < FLUSH_STAGES && k < NUM_STAGES; k++) begin
                    r_entries[k].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (sb_if.cnt_clear) begin
            r_stall_count <= '0;
        end else if (w_stall && sb_if.advance && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign sb_if.fwd_sel     = w_fwd_sel;
    assign sb_if.stall       = w_stall;
    assign sb_if.stall_count = r_stall_count;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the pipelined RV32I core. It sits beside the ID stage. It keeps its own shift register of destination tags for every in-flight instruction from EX through the last write-back stage. Each cycle it tells the ID/EX operand muxes which stage, if any, supplies each source operand. It raises a stall for load-use hazards, honours pipeline freeze and flush, and counts stall cycles for performance monitoring.

## Interface
- `NUM_SRC`, 2: number of source operands checked per instruction.
- `NUM_STAGES`, 3: tracked stages after ID (1 = EX, 2 = MEM, 3 = WB).
- `LOAD_READY_STAGE`, 2: first stage index whose load result can be forwarded.
- `FLUSH_STAGES`, 1: number of youngest stages cleared by `flush`.
- `CNT_W`, 32: stall counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs` in NUM_SRC×5: source register addresses.
- `id_rs_used` in NUM_SRC: source is actually read.
- `id_rd` in 5: destination register.
- `id_load_regfile` in 1: instruction writes rd.
- `id_mem_read` in 1: instruction is a load.
- `advance` in 1: pipeline moves this cycle; low means frozen (e.g. dmem wait).
- `flush` in 1: kill the youngest FLUSH_STAGES entries (branch redirect).
- `cnt_clear` in 1: synchronous clear of the stall counter.
- `fwd_sel` out NUM_SRC×SEL_W: per source; 0 = register file, k = forward from stage k. SEL_W = $clog2(NUM_STAGES+1).
- `stall` out 1: hold PC and IF/ID, insert a bubble into stage 1.
- `stall_count` out CNT_W: saturating count of stalled advancing cycles.

## Operation
- Each stage k has one entry: {valid, rd, wr, ld}.
- Match for source s at stage k:
  - `id_rs_used[s]` and `id_rs[s] != 0` and entry k is valid;
  - entry k has `wr` set, and `rd == id_rs[s]`.
- Entries with `rd == 0` never match.
- Priority: the smallest matching k (youngest instruction) wins.
  - `fwd_sel[s]` = that k, or 0 when there is no match.
- Hazard for source s: the winning entry has `ld` set and k < LOAD_READY_STAGE.
- `stall` = `id_valid` AND (OR of all source hazards).
- While `stall` is high, `fwd_sel` is still driven; consumers ignore it.
- Update when `advance` is high:
  - entry[k] <= entry[k-1] for k ≥ 2.
  - entry[1] <= {id_valid & ~stall, id_rd, id_load_regfile, id_mem_read}.
  - An entry written with valid = 0 is a bubble.
- Update when `advance` is low: all entries hold, regardless of `stall`.
- `flush` (applied after the shift/hold above): entries 1..FLUSH_STAGES become invalid. A flush while frozen still clears them.
- Counter:
  - `stall_count` increments when `stall & advance`, saturating at all-ones.
  - `cnt_clear` forces 0 and has priority over increment.

## Timing
- `fwd_sel` and `stall` are combinational from current entries and ID inputs; same-cycle, no latency.
- Entries and counter update on the rising edge of `clk`.
- A load entering stage 1 at edge n forces `stall` for the dependent ID instruction during cycle n→n+1 (with default params). Forwarding from stage 2 follows after the next advancing edge.
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - all entries invalid;
  - `stall_count` = 0;
  - therefore `fwd_sel` = 0 and `stall` = 0.
- Reset mid-operation discards all in-flight tags, with no partial state.
- Simultaneous `flush` & `stall`: flush wins for the stage-1 slot (it is a bubble either way). The counter still counts the cycle if `advance` is high.

## Structure
- Shared package `rv32i_types`:
  - `sb_entry_t` struct {valid, rd[4:0], wr, ld};
  - `fwd_sel_t`, sized by SEL_W for the default configuration.
- Shared package also holds the encoding constants FWD_REGFILE = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3.
- One sub-module `sb_src_match`, instantiated NUM_SRC times. It takes the entry vector plus one rs and returns the priority-encoded k and the hazard bit.
- The top holds the entry shift register, flush logic and counter.

## Test plan
- Default params. ID `add x3,x1,x2`; stage1 {v,rd=1,wr,!ld}; stage3 {v,rd=2,wr} → `fwd_sel` = {1,3}, `stall` = 0.
- Stage1 = load to x5; ID uses x5 as rs2 → `stall` = 1, `stall_count` +1. Next advance makes stage1 a bubble and stage2 the load → `stall` = 0, `fwd_sel[1]` = 2.
- Stage1 and stage2 both write x7, no loads → `fwd_sel` = 1 (youngest wins). With rd = 0 in stage1 and rs = x0 → `fwd_sel` = 0.
- `advance` = 0 for 3 cycles with a load in stage1 → entries unchanged, `stall` held at 1, `stall_count` unchanged. `cnt_clear` → 0 next edge.
- `flush` with stage1 = load to x5 → next cycle stage1 invalid; a dependent ID instruction sees no stall. Asserting `rst` mid-sequence → all outputs 0 immediately.
- Counter preset near all-ones (CNT_W = 4, 15 stalls) → holds at 15 on further stalls.
